// File: rtl/vga_spi_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_spi_cmd_rx_pkg
// Purpose : Shared command codes, frame geometry and parser state encodings
//           for the VGA SPI command receiver. The VGA top imports the same
//           package so both ends agree on the protocol.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vga_spi_cmd_rx_pkg;

    localparam logic [7:0]  c_CMD_SET_ADDR  = 8'h40;
    localparam logic [7:0]  c_CMD_WRITE     = 8'h41;
    localparam int unsigned c_PAYLOAD_BYTES = 3;
    localparam int unsigned c_FB_ADDR_W     = 19;

    // Payload bytes are counted down from c_PAYLOAD_BYTES to 1.
    localparam int unsigned c_PAYLOAD_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } parserState_t;

endpackage : vga_spi_cmd_rx_pkg
`default_nettype wire

// File: rtl/vga_spi_cmd_rx_byte_rx.sv
`default_nettype none
// ============================================================================
// Module  : vga_spi_cmd_rx_byte_rx
// Purpose : Oversampling SPI mode-0 byte receiver. Synchronises Sclk, Mosi
//           and CSel into the system clock, detects Sclk rising edges while
//           selected, assembles MSB-first bytes and flags a chip-select idle
//           timeout used to resynchronise the command parser.
// Ports   : clk           system clock
//           rst_n         asynchronous active-low reset
//           i_sclk        SPI clock (asynchronous)
//           i_mosi        SPI data (asynchronous)
//           i_csel        SPI chip select, active low (asynchronous)
//           o_byteStb     one-cycle pulse, o_byteData holds a complete byte
//           o_byteData    received byte, valid while o_byteStb is high
//           o_idleTimeout one-cycle pulse after IDLE_TIMEOUT cycles of CSel high
// Revision: 1.0 - initial release
// ============================================================================
module vga_spi_cmd_rx_byte_rx #(
    parameter int unsigned IDLE_TIMEOUT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_csel,
    output logic       o_byteStb,
    output logic [7:0] o_byteData,
    output logic       o_idleTimeout
);

    localparam int unsigned c_IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(IDLE_TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);

    // Index [1] is the synchronised value; index [2] is one cycle older and
    // only exists for the edge detectors.
    logic [2:0]          r_sclkSync;
    logic [1:0]          r_mosiSync;
    logic [2:0]          r_cselSync;
    logic [7:0]          r_shift;
    logic [2:0]          r_bitCnt;
    logic                r_byteStb;
    logic [c_IDLE_W-1:0] r_idleCnt;
    logic                r_idleTimeout;

    logic w_sclkRise;
    logic w_cselFall;
    logic w_cselHigh;

    assign w_cselHigh = r_cselSync[1];
    assign w_sclkRise = r_sclkSync[1] & ~r_sclkSync[2] & ~w_cselHigh;
    assign w_cselFall = ~r_cselSync[1] & r_cselSync[2];

    // Synchronisers reset to the idle bus state so a reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclkSync <= 3'b000;
            r_mosiSync <= 2'b00;
            r_cselSync <= 3'b111;
        end else begin
            r_sclkSync <= {r_sclkSync[1:0], i_sclk};
            r_mosiSync <= {r_mosiSync[0], i_mosi};
            r_cselSync <= {r_cselSync[1:0], i_csel};
        end
    end

    // Mosi passes through the same two flops as Sclk, so at the detected
    // rise it shows the level the master held at its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 8'h00;
            r_bitCnt  <= 3'd0;
            r_byteStb <= 1'b0;
        end else begin
            r_byteStb <= 1'b0;
            // Deselect (or a fresh select) throws away any partial byte.
            if (w_cselHigh || w_cselFall) begin
                r_bitCnt <= 3'd0;
            end else if (w_sclkRise) begin
                r_shift <= {r_shift[6:0], r_mosiSync[1]};
                if (r_bitCnt == 3'd7) begin
                    r_byteStb <= 1'b1;
                    r_bitCnt  <= 3'd0;
                end else begin
                    r_bitCnt <= r_bitCnt + 3'd1;
                end
            end
        end
    end

    // Saturating idle counter; the timeout pulse fires once per idle period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idleCnt     <= '0;
            r_idleTimeout <= 1'b0;
        end else begin
            if (!w_cselHigh) begin
                r_idleCnt <= '0;
            end else if (r_idleCnt != c_IDLE_MAX) begin
                r_idleCnt <= r_idleCnt + c_IDLE_W'(1);
            end
            r_idleTimeout <= w_cselHigh && (r_idleCnt == c_IDLE_LAST);
        end
    end

    assign o_byteStb     = r_byteStb;
    assign o_byteData    = r_shift;
    assign o_idleTimeout = r_idleTimeout;

endmodule : vga_spi_cmd_rx_byte_rx
`default_nettype wire

// File: rtl/vga_spi_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module  : vga_spi_cmd_rx
// Purpose : SPI slave front end and command parser for the VGA top. Decodes
//           SET_ADDR (0x40 + 3 address bytes) and WRITE_PIXELS (0x41 + 3 pixel
//           bytes) frames and queues framebuffer write requests in a small
//           FIFO drained by the SRAM arbiter.
// Ports   : MainClk  system clock
//           RstN     asynchronous active-low reset
//           Sclk     SPI clock, mode 0, at most MainClk/4
//           Mosi     SPI data, MSB first
//           CSel     SPI chip select, active low
//           WrValid  write request available
//           WrReady  arbiter accepts the head request this cycle
//           WrAddr   framebuffer byte address of the head request
//           WrData   pixel byte of the head request
//           Overflow sticky, a pixel byte was dropped on a full FIFO;
//                    cleared by the next completed SET_ADDR
// Revision: 1.0 - initial release
// ============================================================================
module vga_spi_cmd_rx
    import vga_spi_cmd_rx_pkg::*;
#(
    parameter int unsigned ADDR_W       = c_FB_ADDR_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned IDLE_TIMEOUT = 6
) (
    input  logic              MainClk,
    input  logic              RstN,
    input  logic              Sclk,
    input  logic              Mosi,
    input  logic              CSel,
    output logic              WrValid,
    input  logic              WrReady,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        WrData,
    output logic              Overflow
);

    localparam int unsigned c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned c_ENTRY_W = ADDR_W + 8;
    localparam int unsigned c_SHADOW_W = 8 * c_PAYLOAD_BYTES;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PAYLOAD_CNT_W-1:0] c_PAYLOAD_INIT = c_PAYLOAD_CNT_W'(c_PAYLOAD_BYTES);

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    logic       w_byteStb;
    logic [7:0] w_byteData;
    logic       w_idleTimeout;

    vga_spi_cmd_rx_byte_rx #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_byteRx (
        .clk           (MainClk),
        .rst_n         (RstN),
        .i_sclk        (Sclk),
        .i_mosi        (Mosi),
        .i_csel        (CSel),
        .o_byteStb     (w_byteStb),
        .o_byteData    (w_byteData),
        .o_idleTimeout (w_idleTimeout)
    );

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    parserState_t               r_state;
    parserState_t               w_stateNext;
    logic [c_PAYLOAD_CNT_W-1:0] r_cnt;
    logic [c_PAYLOAD_CNT_W-1:0] w_cntNext;
    logic [c_SHADOW_W-1:0]      r_shadow;
    logic [c_SHADOW_W-1:0]      w_shadowNext;
    logic [c_SHADOW_W-1:0]      w_shadowShift;
    logic [ADDR_W-1:0]          r_wptr;
    logic [ADDR_W-1:0]          w_wptrNext;
    logic                       w_push;
    logic                       w_addrDone;

    assign w_shadowShift = {r_shadow[c_SHADOW_W-9:0], w_byteData};

    always_ff @(posedge MainClk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_shadowNext = r_shadow;
        w_wptrNext   = r_wptr;
        w_push       = 1'b0;
        w_addrDone   = 1'b0;

        if (w_byteStb) begin
            case (r_state)
                ST_CMD: begin
                    if (w_byteData == c_CMD_SET_ADDR) begin
                        w_stateNext = ST_ADDR;
                        w_cntNext   = c_PAYLOAD_INIT;
                    end else if (w_byteData == c_CMD_WRITE) begin
                        w_stateNext = ST_DATA;
                        w_cntNext   = c_PAYLOAD_INIT;
                    end
                end
                ST_ADDR: begin
                    w_shadowNext = w_shadowShift;
                    w_cntNext    = r_cnt - 1'b1;
                    if (r_cnt == 1) begin
                        // Upper shadow bits beyond ADDR_W are don't-care.
                        w_wptrNext  = w_shadowShift[ADDR_W-1:0];
                        w_addrDone  = 1'b1;
                        w_stateNext = ST_CMD;
                    end
                end
                ST_DATA: begin
                    // The pointer advances even when the FIFO drops the byte,
                    // so later pixels still land at their intended addresses.
                    w_push     = 1'b1;
                    w_wptrNext = r_wptr + ADDR_W'(1);
                    w_cntNext  = r_cnt - 1'b1;
                    if (r_cnt == 1) begin
                        w_stateNext = ST_CMD;
                    end
                end
                default: begin
                    w_stateNext = ST_CMD;
                end
            endcase
        end

        // A coincident byte is still consumed above; only the framing resets.
        if (w_idleTimeout) begin
            w_stateNext  = ST_CMD;
            w_cntNext    = '0;
            w_shadowNext = '0;
        end
    end

    logic                 r_pushReq;
    logic [c_ENTRY_W-1:0] r_pushEntry;
    logic                 r_overflow;
    logic                 w_drop;

    always_ff @(posedge MainClk or negedge RstN) begin
        if (!RstN) begin
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_wptr      <= '0;
            r_pushReq   <= 1'b0;
            r_pushEntry <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_cnt     <= w_cntNext;
            r_shadow  <= w_shadowNext;
            r_wptr    <= w_wptrNext;
            r_pushReq <= w_push;
            if (w_push) begin
                r_pushEntry <= {r_wptr, w_byteData};
            end
            if (w_addrDone) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-request FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_fifoWr;
    logic [c_PTR_W-1:0]   r_fifoRd;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_countNext;
    logic                 r_wrValid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_write;

    assign w_full  = (r_count == c_FULL);
    assign w_pop   = r_wrValid & WrReady;
    // When full, a same-cycle pop frees the head slot the write lands in.
    assign w_write = r_pushReq & (~w_full | w_pop);
    assign w_drop  = r_pushReq & w_full & ~w_pop;

    always_comb begin
        w_countNext = r_count;
        case ({w_write, w_pop})
            2'b10:   w_countNext = r_count + c_CNT_W'(1);
            2'b01:   w_countNext = r_count - c_CNT_W'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge MainClk or negedge RstN) begin
        if (!RstN) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_fifoWr  <= '0;
            r_fifoRd  <= '0;
            r_count   <= '0;
            r_wrValid <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_fifoWr] <= r_pushEntry;
                r_fifoWr        <= r_fifoWr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_fifoRd <= r_fifoRd + c_PTR_W'(1);
            end
            r_count   <= w_countNext;
            r_wrValid <= (w_countNext != '0);
        end
    end

    assign WrValid  = r_wrValid;
    assign WrAddr   = r_mem[r_fifoRd][c_ENTRY_W-1:8];
    assign WrData   = r_mem[r_fifoRd][7:0];
    assign Overflow = r_overflow;

endmodule : vga_spi_cmd_rx
`default_nettype wire
